ins_fetch_unit: RTL and testbench

//   Instruction fetch engine feeding the instruction register. Reads one 32-bit instruction

---
 rtl/ins_fetch_unit_pkg.sv | 18 +
 rtl/ins_fetch_unit_if.sv | 30 +++
 rtl/ins_fetch_unit.sv | 107 ++++++++++
 tb/tb_ins_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_fetch_unit_pkg.sv
// ins_fetch_unit shared types: fetch FSM encoding and word geometry.
// Used by ins_fetch_unit and its interface.
package ins_fetch_unit_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Big-endian lane: byte 0 lands in [31:24], byte 3 in [7:0].
  function automatic logic [4:0] byte_lsb(input logic [1:0] cnt);
    byte_lsb = 5'(8 * (BYTES_PER_WORD - 1 - int'(cnt)));
  endfunction

endpackage

// File: rtl/ins_fetch_unit_if.sv
// ins_fetch_unit_if: control, memory and IR-side signals of the fetch unit.
// master = fetch engine, slave = control unit / memory / IR side.
interface ins_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_start;
  logic [ADDR_W-1:0] fetch_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_byte;
  logic [31:0]       Ins_Data;
  logic              IRWre;
  logic              busy;
  logic              fault;

  modport master (
    input  fetch_start, fetch_addr,
    input  mem_ack, mem_byte,
    output mem_req, mem_addr,
    output Ins_Data, IRWre, busy, fault
  );

  modport slave (
    output fetch_start, fetch_addr,
    output mem_ack, mem_byte,
    input  mem_req, mem_addr,
    input  Ins_Data, IRWre, busy, fault
  );
endinterface

// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit: 4 big-endian byte reads -> 32-bit word + IRWre strobe.
// Optional macro FETCH_ALIGN_CHECK_EN rejects unaligned fetch_addr.
module ins_fetch_unit
  import ins_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  ins_fetch_unit_if.master       bus
);

  localparam int WW = $clog2(TIMEOUT + 1);

  fetch_state_t      state_q;
  logic [1:0]        cnt_q;
  logic [WW-1:0]     wait_q;
  logic [31:0]       buf_q;
  logic [31:0]       ins_q;
  logic              irwre_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  logic              fault_q;
  logic              start_ok;

`ifdef FETCH_ALIGN_CHECK_EN
  assign start_ok = (bus.fetch_addr[1:0] == 2'b00);
`else
  assign start_ok = 1'b1;
`endif

  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;
  assign bus.Ins_Data = ins_q;
  assign bus.IRWre    = irwre_q;
  assign bus.busy     = busy_q;
  assign bus.fault    = fault_q;

  // Fetch FSM: collects bytes, times out stalled reads, strobes IR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      buf_q   <= '0;
      ins_q   <= '0;
      irwre_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      irwre_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.fetch_start) begin
            if (start_ok) begin
              fault_q <= 1'b0;
              req_q   <= 1'b1;
              addr_q  <= bus.fetch_addr;
              cnt_q   <= '0;
              wait_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= REQ;
            end else begin
              fault_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            buf_q[byte_lsb(cnt_q) +: 8] <= bus.mem_byte;
            cnt_q  <= cnt_q + 2'd1;
            wait_q <= '0;
            addr_q <= addr_q + ADDR_W'(1);
            if (cnt_q == 2'd3) begin
              req_q   <= 1'b0;
              state_q <= DONE;
            end
          end else if (wait_q == WW'(TIMEOUT - 1)) begin
            fault_q <= 1'b1;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            wait_q  <= '0;
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        DONE: begin
          ins_q   <= buf_q;
          irwre_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_fetch_unit.sv
// tb_ins_fetch_unit: directed fetch scenarios, transaction model,
// per-cycle output compare plus literal expectations.
module tb_ins_fetch_unit;

  localparam int TIMEOUT = 16;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;

  ins_fetch_unit_if #(.ADDR_W(32)) bus ();

  ins_fetch_unit #(
    .ADDR_W (32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.master)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Transaction-level model
  bit          m_act   = 0;
  int          m_got   = 0;
  int          m_wait  = 0;
  bit          m_fault = 0;
  bit          m_irw   = 0;
  logic [31:0] m_word  = '0;
  logic [31:0] m_base  = '0;
  logic [7:0]  m_bytes[$];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_act = 0; m_got = 0; m_wait = 0;
      m_fault = 0; m_irw = 0; m_word = '0;
      m_base = '0; m_bytes.delete();
    end else begin
      m_irw = 0;
      if (!m_act) begin
        if (bus.fetch_start) begin
          if (ALIGN && bus.fetch_addr[1:0] != 2'b00) begin
            m_fault = 1;
          end else begin
            m_act = 1; m_got = 0; m_wait = 0;
            m_fault = 0; m_base = bus.fetch_addr;
            m_bytes.delete();
          end
        end
      end else if (m_got < 4) begin
        if (bus.mem_ack) begin
          m_bytes.push_back(bus.mem_byte);
          m_got++;
          m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_fault = 1;
            m_act = 0;
          end
        end
      end else begin
        m_word = {m_bytes[0], m_bytes[1],
                  m_bytes[2], m_bytes[3]};
        m_irw = 1;
        m_act = 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge CLK) begin
    if (!RST) begin
      chk("busy", 32'(bus.busy), 32'(m_act));
      chk("mem_req", 32'(bus.mem_req),
          32'(m_act && m_got < 4));
      if (m_act && m_got < 4)
        chk("mem_addr", bus.mem_addr,
            m_base + 32'(m_got));
      chk("IRWre", 32'(bus.IRWre), 32'(m_irw));
      chk("Ins_Data", bus.Ins_Data, m_word);
      chk("fault", 32'(bus.fault), 32'(m_fault));
    end
  end

  // Observation helpers for literal checks
  int          cyc = 0;
  int          start_cyc = 0;
  int          irw_cyc = 0;
  int          irw_cnt = 0;
  int          req_cnt = 0;
  logic [31:0] addr_q[$];

  always @(posedge CLK) begin
    cyc++;
    if (bus.fetch_start && !bus.busy) start_cyc = cyc;
    if (bus.mem_req && bus.mem_ack)
      addr_q.push_back(bus.mem_addr);
    if (bus.mem_req) req_cnt++;
  end

  always @(negedge CLK) begin
    if (bus.IRWre) begin
      irw_cnt++;
      irw_cyc = cyc;
    end
  end

  task automatic clear_obs();
    irw_cnt = 0;
    req_cnt = 0;
    addr_q.delete();
  endtask

  task automatic do_fetch(input logic [31:0] a,
                          input logic [31:0] w,
                          input int gap);
    @(negedge CLK);
    clear_obs();
    bus.fetch_start = 1'b1;
    bus.fetch_addr  = a;
    @(negedge CLK);
    bus.fetch_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (gap) @(negedge CLK);
      bus.mem_ack  = 1'b1;
      bus.mem_byte = w[31-8*i -: 8];
      @(negedge CLK);
      bus.mem_ack  = 1'b0;
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic chk_addrs(input string nm,
                           input logic [31:0] a0);
    chk({nm, "_n"}, 32'(addr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      chk(nm, addr_q[i], a0 + 32'(i));
  endtask

  initial begin
    bus.fetch_start = 1'b0;
    bus.fetch_addr  = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_byte    = '0;

    #2;
    chk("rst_ins", bus.Ins_Data, 32'h0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // 1: zero-wait fetch
    do_fetch(32'h0000_0010, 32'h8C22_0004, 0);
    chk("t1_word", bus.Ins_Data, 32'h8C22_0004);
    chk("t1_irw", 32'(irw_cnt), 32'd1);
    chk("t1_lat", 32'(irw_cyc - start_cyc), 32'd5);
    chk_addrs("t1_addr", 32'h0000_0010);

    // 2: three idle cycles before each ack
    do_fetch(32'h0000_0010, 32'h8C22_0004, 3);
    chk("t2_word", bus.Ins_Data, 32'h8C22_0004);
    chk("t2_irw", 32'(irw_cnt), 32'd1);
    chk("t2_fault", 32'(bus.fault), 32'd0);
    chk_addrs("t2_addr", 32'h0000_0010);

    // 3: no ack -> timeout
    @(negedge CLK);
    clear_obs();
    bus.fetch_start = 1'b1;
    bus.fetch_addr  = 32'h0000_0040;
    @(negedge CLK);
    bus.fetch_start = 1'b0;
    repeat (TIMEOUT - 1) @(negedge CLK);
    chk("t3_nofault", 32'(bus.fault), 32'd0);
    @(negedge CLK);
    chk("t3_fault", 32'(bus.fault), 32'd1);
    chk("t3_busy", 32'(bus.busy), 32'd0);
    chk("t3_req_cyc", 32'(req_cnt), 32'(TIMEOUT));
    repeat (4) @(negedge CLK);
    chk("t3_irw", 32'(irw_cnt), 32'd0);
    chk("t3_keep", bus.Ins_Data, 32'h8C22_0004);

    // 4: address wrap, clears fault
    do_fetch(32'hFFFF_FFFE, 32'hA1B2_C3D4, 0);
    chk("t4_word", bus.Ins_Data, 32'hA1B2_C3D4);
    chk("t4_fault", 32'(bus.fault), 32'd0);
    chk_addrs("t4_addr", 32'hFFFF_FFFE);

    // 5: reset after second ack
    @(negedge CLK);
    bus.fetch_start = 1'b1;
    bus.fetch_addr  = 32'h0000_0080;
    @(negedge CLK);
    bus.fetch_start = 1'b0;
    bus.mem_ack  = 1'b1;
    bus.mem_byte = 8'h11;
    @(negedge CLK);
    bus.mem_byte = 8'h22;
    @(negedge CLK);
    bus.mem_ack  = 1'b0;
    #1 RST = 1'b1;
    #1;
    chk("t5_ins", bus.Ins_Data, 32'h0);
    chk("t5_req", 32'(bus.mem_req), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_irw", 32'(bus.IRWre), 32'd0);
    chk("t5_addr", bus.mem_addr, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    do_fetch(32'h0000_0020, 32'h1357_9BDF, 1);
    chk("t5_word", bus.Ins_Data, 32'h1357_9BDF);
    chk("t5_irw1", 32'(irw_cnt), 32'd1);

    // 6: unaligned base
    @(negedge CLK);
    clear_obs();
    bus.fetch_start = 1'b1;
    bus.fetch_addr  = 32'h0000_0002;
    @(negedge CLK);
    bus.fetch_start = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t6_fault", 32'(bus.fault), 32'd1);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    repeat (4) @(negedge CLK);
    chk("t6_noreq", 32'(req_cnt), 32'd0);
    chk("t6_keep", bus.Ins_Data, 32'h1357_9BDF);
`else
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack  = 1'b1;
      bus.mem_byte = 8'(8'hF0 + i);
      @(negedge CLK);
    end
    bus.mem_ack = 1'b0;
    repeat (3) @(negedge CLK);
    chk("t6_word", bus.Ins_Data, 32'hF0F1_F2F3);
    chk("t6_fault", 32'(bus.fault), 32'd0);
    chk_addrs("t6_addr", 32'h0000_0002);
`endif

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
